// File: rtl/activation_quant_if.sv
// Sample-in / quantized-element-out handshake bundle for activation_quant.
// slave is the quantizer side, master is the producer/consumer side.
interface activation_quant_if #(
    parameter int IPREC = 8,
    parameter int OPREC = 32
);
    logic                    i_valid;
    logic signed [OPREC-1:0] i_data;
    logic [4:0]              i_shift;
    logic                    o_ready;
    logic                    o_valid;
    logic signed [IPREC-1:0] o_result;
    logic                    i_ready;
    logic [15:0]             o_sat_cnt;

    modport slave (
        input  i_valid, i_data, i_shift, i_ready,
        output o_ready, o_valid, o_result, o_sat_cnt
    );

    modport master (
        output i_valid, i_data, i_shift, i_ready,
        input  o_ready, o_valid, o_result, o_sat_cnt
    );
endinterface

// File: rtl/activation_quant.sv
// Round-shift-clip quantizer: OPREC-bit accumulator sample -> IPREC-bit element (ReLU when RELU_EN is defined).
// Latency 3 cycles from accept to FIFO head (shift stage, clip stage, FWFT output FIFO), no bubbles.
// Backpressure: o_ready drops once pipeline plus FIFO hold DEPTH samples, so the pipeline itself never stalls.
module activation_quant #(
    parameter int IPREC = 8,
    parameter int OPREC = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    activation_quant_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic signed [OPREC:0] MAX_V = {{(OPREC-IPREC+2){1'b0}}, {(IPREC-1){1'b1}}};
    localparam logic signed [OPREC:0] MIN_V = {{(OPREC-IPREC+2){1'b1}}, {(IPREC-1){1'b0}}};
    localparam logic signed [IPREC-1:0] QMAX = {1'b0, {(IPREC-1){1'b1}}};
    localparam logic signed [IPREC-1:0] QMIN = {1'b1, {(IPREC-1){1'b0}}};

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic signed [OPREC:0]   rnd;
    logic signed [OPREC:0]   sum;
    logic signed [OPREC:0]   s1_next;
    logic                    s1_vld;
    logic signed [OPREC:0]   s1_dat;
    logic signed [OPREC:0]   clip_in;
    logic signed [IPREC-1:0] clip_dat;
    logic                    clip_sat;
    logic                    s2_vld;
    logic signed [IPREC-1:0] s2_dat;
    logic [15:0]             sat_cnt;

    logic signed [IPREC-1:0] mem [DEPTH];
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic [AW:0]             count;
    logic [AW+1:0]           occ;

    // Every sample already accepted holds a slot, so a full FIFO can never be pushed.
    assign occ         = (AW+2)'(count) + (AW+2)'(s1_vld) + (AW+2)'(s2_vld);
    assign bus.o_ready = (occ < (AW+2)'(DEPTH));
    assign accept      = bus.i_valid & bus.o_ready;

    // Round half up: add 2^(shift-1), computed as (1 << shift) >> 1 so shift 0 adds nothing.
    always_comb begin
        rnd     = ((OPREC+1)'(1) << bus.i_shift) >> 1;
        sum     = {bus.i_data[OPREC-1], bus.i_data} + rnd;
        s1_next = sum >>> bus.i_shift;
    end

    always_comb begin
        clip_in  = s1_dat;
`ifdef RELU_EN
        if (s1_dat[OPREC]) begin
            clip_in = '0;
        end
`endif
        clip_dat = clip_in[IPREC-1:0];
        clip_sat = 1'b0;
        if (clip_in > MAX_V) begin
            clip_dat = QMAX;
            clip_sat = 1'b1;
        end else if (clip_in < MIN_V) begin
            clip_dat = QMIN;
            clip_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s2_vld  <= 1'b0;
            s2_dat  <= '0;
            sat_cnt <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_dat <= s1_next;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dat <= clip_dat;
                if (clip_sat && (sat_cnt != 16'hFFFF)) begin
                    sat_cnt <= sat_cnt + 16'd1;
                end
            end
        end
    end

    assign push = s2_vld;
    assign pop  = bus.o_valid & bus.i_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= s2_dat;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count alone tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.o_valid   = (count != '0);
    assign bus.o_result  = bus.o_valid ? mem[rptr] : '0;
    assign bus.o_sat_cnt = sat_cnt;
endmodule

// File: tb/tb_activation_quant.sv
// Scoreboard bench for activation_quant: directed corner cases plus randomized traffic
// against an arithmetic reference model (floor division, explicit clamp).
module tb_activation_quant;
    localparam int IPREC = 8;
    localparam int OPREC = 32;
    localparam int DEPTH = 4;
    localparam longint QMAX = (longint'(1) << (IPREC-1)) - 1;
    localparam longint QMIN = -(longint'(1) << (IPREC-1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    activation_quant_if #(.IPREC(IPREC), .OPREC(OPREC)) bus ();

    activation_quant #(.IPREC(IPREC), .OPREC(OPREC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    longint exp_q[$];
    bit     sat_q[$];
    int     sat_acc = 0;
    int     sat_pop = 0;
    int     n_acc = 0;
    bit     rand_rdy = 1'b0;
    longint mon_e;
    bit     mon_s;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round half up, then floor-divide by 2^sh, optional ReLU, clamp to the output range.
    function automatic longint model(input longint d, input int sh, output bit sat);
        longint p;
        longint v;
        p = longint'(1) << sh;
        v = d + p / 2;
        if (v >= 0) v = v / p;
        else        v = -((-v + p - 1) / p);
        sat = 1'b0;
`ifdef RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > QMAX) begin
            v = QMAX;
            sat = 1'b1;
        end else if (v < QMIN) begin
            v = QMIN;
            sat = 1'b1;
        end
        return v;
    endfunction

    // Holds the sample on the bus until accepted; returns at posedge+1 of the accept edge.
    task automatic send(input longint d, input int sh, input bit has_exp, input longint exp_v,
                        output int waited);
        bit     rdy;
        bit     s;
        longint m;
        waited        = 0;
        bus.i_valid   = 1'b1;
        bus.i_data    = d[OPREC-1:0];
        bus.i_shift   = sh[4:0];
        forever begin
            rdy = bus.o_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: sample %0d not accepted, waited %0d cycles", d, waited);
                return;
            end
        end
        m = model(d, sh, s);
        exp_q.push_back(has_exp ? exp_v : m);
        sat_q.push_back(s);
        sat_acc += int'(s);
        n_acc++;
    endtask

    task automatic drain();
        int n;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d, expected no output", bus.o_result);
            end else begin
                mon_e = exp_q.pop_front();
                mon_s = sat_q.pop_front();
                check("result", longint'(bus.o_result), mon_e);
                sat_pop += int'(mon_s);
                checks++;
                if (int'(bus.o_sat_cnt) < sat_pop || int'(bus.o_sat_cnt) > sat_acc) begin
                    errors++;
                    $display("FAIL sat_cnt_range: got %0d, required %0d..%0d",
                             bus.o_sat_cnt, sat_pop, sat_acc);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.i_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;
        int sh;
        longint d;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_shift = '0;
        bus.i_ready = 1'b0;

        // Reset held from time zero, before any clock edge.
        #2;
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_o_result", bus.o_result, 0);
        check("rst_o_ready", bus.o_ready, 1);
        check("rst_o_sat_cnt", bus.o_sat_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: visible after the third edge counting the accept edge, gone after the pop.
        bus.i_ready = 1'b1;
        send(1000, 3, 1'b1, 125, w);
        bus.i_valid = 1'b0;
        @(negedge clk); check("lat_e0_valid", bus.o_valid, 0);
        @(negedge clk); check("lat_e1_valid", bus.o_valid, 0);
        @(negedge clk); check("lat_e2_valid", bus.o_valid, 1);
                        check("lat_e2_result", longint'(bus.o_result), 125);
        @(negedge clk); check("lat_e3_valid", bus.o_valid, 0);
        @(posedge clk); #1;

`ifdef RELU_EN
        send(-3, 1, 1'b1, 0, w);
        send(100000, 0, 1'b1, 127, w);
        send(-5000, 0, 1'b1, 0, w);
        drain();
        check("sat_after_directed", bus.o_sat_cnt, 1);
`else
        send(-3, 1, 1'b1, -1, w);
        send(100000, 0, 1'b1, 127, w);
        send(-5000, 0, 1'b1, -128, w);
        drain();
        check("sat_after_directed", bus.o_sat_cnt, 2);
`endif

        // Backpressure: only DEPTH samples fit with the consumer stalled.
        bus.i_ready = 1'b0;
        base = n_acc;
        for (int v = 1; v <= 4; v++) send(v, 0, 1'b1, v, w);
        check("full_o_ready", bus.o_ready, 0);
        fork
            begin
                send(5, 0, 1'b1, 5, w);
                send(6, 0, 1'b1, 6, w);
                bus.i_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check("stall_o_ready", bus.o_ready, 0);
                check("stall_accepted", n_acc - base, 4);
                bus.i_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with 3 buffered and 1 in stage 1.
        bus.i_ready = 1'b0;
        send(11, 0, 1'b0, 0, w);
        send(12, 0, 1'b0, 0, w);
        send(13, 0, 1'b0, 0, w);
        bus.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(14, 0, 1'b0, 0, w);
        bus.i_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_o_valid", bus.o_valid, 0);
        check("arst_o_ready", bus.o_ready, 1);
        check("arst_o_result", bus.o_result, 0);
        check("arst_o_sat_cnt", bus.o_sat_cnt, 0);
        exp_q.delete();
        sat_q.delete();
        sat_acc = 0;
        sat_pop = 0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(21, 0, 1'b1, 21, w);
        check("accept_first_edge", w, 0);
        drain();

        // Randomized traffic with random consumer stalls and producer gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(2))
                0: begin
                    sh = $urandom_range(3);
                    d  = longint'($urandom_range(600)) - 300;
                end
                1: begin
                    sh = $urandom_range(31);
                    d  = longint'($signed($urandom()));
                end
                default: begin
                    sh = $urandom_range(16);
                    d  = longint'($urandom_range(2 ** 18)) * (longint'(1) << sh) / 1024
                         - (longint'(1) << (sh + 7));
                end
            endcase
            send(d, sh, 1'b0, 0, w);
            if ($urandom_range(3) == 0) begin
                bus.i_valid = 1'b0;
                repeat ($urandom_range(3)) @(posedge clk);
                #1;
            end
        end
        bus.i_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        drain();
        check("sat_after_random", bus.o_sat_cnt, sat_acc);
        check("idle_o_ready", bus.o_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
